// File: rtl/hamming_secded_serial_decoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_serial_decoder
//
// Bit-serial Hamming(2^M-1, 2^M-1-M) decoder with optional extended overall
// parity (SEC-DED). Code bits arrive one per accepted strobe in position order
// 1..N, followed by the overall parity bit when EXT_PARITY=1. The syndrome and
// overall parity are accumulated bit by bit as the frame streams in, so the
// decode stage only has to apply a single-bit flip and pick out the data bits.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   ena          bit strobe; bit_in is taken on a rising clk edge when ena=1
//   sync         frame restart; with ena=1 bit_in becomes position 1,
//                with ena=0 the counter and accumulators clear
//   bit_in       serial code bit
//   data_out     decoded data, [0] = position 3, ascending over the
//                non-power-of-two positions
//   valid_out    one-cycle pulse when data_out / flags / syndrome_out update
//   corrected    a single error was corrected (includes the ext parity bit)
//   double_err   uncorrectable double error (always 0 when EXT_PARITY=0)
//   syndrome_out syndrome of the last decoded frame
//
// Handshake: valid-only, no backpressure. valid_out is high for exactly one
// cycle per completed frame; data_out, corrected, double_err and syndrome_out
// change only on that cycle and hold their values until the next pulse.
// -----------------------------------------------------------------------------
module hamming_secded_serial_decoder #(
  parameter int  M          = 3,
  parameter bit  EXT_PARITY = 1'b1,
  localparam int N          = (1 << M) - 1,
  localparam int K          = N - M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         sync,
  input  logic         bit_in,
  output logic [K-1:0] data_out,
  output logic         valid_out,
  output logic         corrected,
  output logic         double_err,
  output logic [M-1:0] syndrome_out
);

  localparam int L  = N + (EXT_PARITY ? 1 : 0);
  localparam int CW = $clog2(L + 1);

  // Accumulation stage: position of the next accepted bit (1..L).
  logic [CW-1:0] pos_q;
  logic [M-1:0]  syn_q;
  logic          par_q;
  logic [N:1]    cap_q;

  // Decode stage, loaded on the edge that accepts the last bit of a frame.
  logic          dec_pend_q;
  logic [N:1]    dec_cap_q;
  logic [M-1:0]  dec_syn_q;
  logic          dec_par_q;

  logic [CW-1:0] eff_pos;
  logic [M-1:0]  eff_syn;
  logic          eff_par;
  logic [M-1:0]  syn_nxt;
  logic          par_nxt;
  logic [N:1]    cap_nxt;
  logic          last_bit;

  // Pick the data bits (every non-power-of-two position) in ascending order.
  function automatic logic [K-1:0] extract_data(input logic [N:1] cw);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p];
        j++;
      end
    end
    return d;
  endfunction

  // A sync with ena=1 makes the current bit position 1 of a fresh frame, so
  // the accumulators are treated as already cleared for this bit.
  always_comb begin
    eff_pos  = sync ? CW'(1) : pos_q;
    eff_syn  = sync ? '0 : syn_q;
    eff_par  = sync ? 1'b0 : par_q;
    cap_nxt  = cap_q;
    for (int p = 1; p <= N; p++) begin
      if (eff_pos == CW'(p)) cap_nxt[p] = bit_in;
    end
    // The ext parity position (N+1) never touches the syndrome.
    syn_nxt  = eff_syn ^ ((bit_in && (eff_pos <= CW'(N))) ? eff_pos[M-1:0] : '0);
    par_nxt  = eff_par ^ bit_in;
    last_bit = (eff_pos == CW'(L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= CW'(1);
      syn_q      <= '0;
      par_q      <= 1'b0;
      cap_q      <= '0;
      dec_pend_q <= 1'b0;
      dec_cap_q  <= '0;
      dec_syn_q  <= '0;
      dec_par_q  <= 1'b0;
    end else begin
      dec_pend_q <= 1'b0;
      if (ena) begin
        cap_q <= cap_nxt;
        if (last_bit) begin
          pos_q      <= CW'(1);
          syn_q      <= '0;
          par_q      <= 1'b0;
          dec_pend_q <= 1'b1;
          dec_cap_q  <= cap_nxt;
          dec_syn_q  <= syn_nxt;
          dec_par_q  <= par_nxt;
        end else begin
          pos_q <= eff_pos + CW'(1);
          syn_q <= syn_nxt;
          par_q <= par_nxt;
        end
      end else if (sync) begin
        pos_q <= CW'(1);
        syn_q <= '0;
        par_q <= 1'b0;
      end
    end
  end

  logic         flip;
  logic         corr_d;
  logic         derr_d;
  logic [N:1]   fixed_cap;
  logic [K-1:0] data_d;

  always_comb begin
    flip   = 1'b0;
    corr_d = 1'b0;
    derr_d = 1'b0;
    if (EXT_PARITY) begin
      // {syndrome nonzero, overall parity odd}
      unique case ({dec_syn_q != '0, dec_par_q})
        2'b11:   begin flip = 1'b1; corr_d = 1'b1; end
        2'b01:   corr_d = 1'b1;  // only the ext parity bit was hit
        2'b10:   derr_d = 1'b1;  // even parity with nonzero syndrome
        default: ;
      endcase
    end else if (dec_syn_q != '0) begin
      flip   = 1'b1;
      corr_d = 1'b1;
    end
    fixed_cap = dec_cap_q;
    for (int p = 1; p <= N; p++) begin
      if (flip && (dec_syn_q == M'(p))) fixed_cap[p] = ~dec_cap_q[p];
    end
    data_d = extract_data(fixed_cap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      data_out     <= '0;
      corrected    <= 1'b0;
      double_err   <= 1'b0;
      syndrome_out <= '0;
    end else begin
      valid_out <= dec_pend_q;
      if (dec_pend_q) begin
        data_out     <= data_d;
        corrected    <= corr_d;
        double_err   <= derr_d;
        syndrome_out <= dec_syn_q;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_serial_decoder.sv
module tb_hamming_secded_serial_decoder;

  localparam int W = 17;

  typedef struct packed {
    logic [10:0] data;
    logic        corr;
    logic        derr;
    logic [3:0]  syn;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: M=3, EXT=1 (8-bit frames)
  logic       ena_a, sync_a, bit_a;
  logic [3:0] data_a;
  logic       valid_a, corr_a, derr_a;
  logic [2:0] syn_a;

  // DUT B: M=4, EXT=0 (15-bit frames)
  logic        ena_b, sync_b, bit_b;
  logic [10:0] data_b;
  logic        valid_b, corr_b, derr_b;
  logic [3:0]  syn_b;

  hamming_secded_serial_decoder #(.M(3), .EXT_PARITY(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .sync(sync_a), .bit_in(bit_a),
    .data_out(data_a), .valid_out(valid_a), .corrected(corr_a),
    .double_err(derr_a), .syndrome_out(syn_a)
  );

  hamming_secded_serial_decoder #(.M(4), .EXT_PARITY(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .sync(sync_b), .bit_in(bit_b),
    .data_out(data_b), .valid_out(valid_b), .corrected(corr_b),
    .double_err(derr_b), .syndrome_out(syn_b)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- monitor ----------------
  logic [W-1:0] got_a_q[$];
  logic [W-1:0] got_b_q[$];
  int           got_a_cyc[$];
  logic [W-1:0] exp_q[$];
  int           wide_cnt = 0;
  logic         prev_valid_a = 1'b0;

  always @(negedge clk) begin
    if (valid_a) begin
      got_a_q.push_back({7'b0, data_a, corr_a, derr_a, 1'b0, syn_a});
      got_a_cyc.push_back(cyc);
      if (prev_valid_a) wide_cnt <= wide_cnt + 1;
    end
    if (valid_b) got_b_q.push_back({data_b, corr_b, derr_b, syn_b});
    prev_valid_a <= valid_a;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Build a valid codeword: data in the non-power-of-two positions, parity
  // bit 2^i chosen so that the XOR of all set positions is zero.
  function automatic logic [15:0] encode(int m, logic [10:0] d);
    logic [15:0] fr;
    int n, j, s;
    fr = '0; n = (1 << m) - 1; j = 0; s = 0;
    for (int p = 1; p <= n; p++)
      if ((p & (p - 1)) != 0) begin fr[p] = d[j]; j++; end
    for (int p = 1; p <= n; p++) if (fr[p]) s ^= p;
    for (int i = 0; i < m; i++) fr[1 << i] = s[i];
    return fr;
  endfunction

  function automatic res_t model(int m, bit ext, logic [15:0] fr_in, logic xb);
    logic [15:0] f;
    res_t r;
    int n, s, ones, j;
    bit odd;
    f = fr_in; n = (1 << m) - 1; s = 0; ones = 0; j = 0; r = '0;
    for (int p = 1; p <= n; p++) if (f[p]) begin s ^= p; ones++; end
    if (ext && xb) ones++;
    odd = (ones % 2) == 1;
    r.syn = s[3:0];
    if (ext) begin
      if (s != 0 && odd) begin f[s] = ~f[s]; r.corr = 1'b1; end
      else if (s == 0 && odd) r.corr = 1'b1;
      else if (s != 0 && !odd) r.derr = 1'b1;
    end else if (s != 0) begin
      f[s] = ~f[s]; r.corr = 1'b1;
    end
    for (int p = 1; p <= n; p++)
      if ((p & (p - 1)) != 0) begin r.data[j] = f[p]; j++; end
    return r;
  endfunction

  function automatic logic [15:0] st_to_fr(logic [0:7] st);
    logic [15:0] fr;
    fr = '0;
    for (int p = 1; p <= 7; p++) fr[p] = st[p-1];
    return fr;
  endfunction

  // ---------------- drivers ----------------
  task automatic step_a(logic b, logic s);
    bit_a = b; sync_a = s; ena_a = 1'b1;
    @(posedge clk); #1;
    sync_a = 1'b0;
  endtask

  task automatic idle_a(int n);
    ena_a = 1'b0; sync_a = 1'b0;
    repeat (n) begin
      bit_a = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_a(logic [15:0] fr, logic xb, bit use_sync, int gap_at,
                        int gap_len, bit keep_ena, output int first_c,
                        output int last_c);
    first_c = 0; last_c = 0;
    for (int p = 1; p <= 8; p++) begin
      if (p == gap_at) idle_a(gap_len);
      step_a((p <= 7) ? fr[p] : xb, (p == 1) && use_sync);
      if (p == 1) first_c = cyc;
      if (p == 8) last_c = cyc;
    end
    if (!keep_ena) ena_a = 1'b0;
  endtask

  task automatic send_b(logic [15:0] fr);
    for (int p = 1; p <= 15; p++) begin
      bit_b = fr[p]; sync_b = 1'b0; ena_b = 1'b1;
      @(posedge clk); #1;
    end
    ena_b = 1'b0;
  endtask

  task automatic wait_a(int n, output bit ok);
    ena_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (got_a_q.size() >= n) break;
      @(posedge clk); #1;
    end
    ok = (got_a_q.size() >= n);
  endtask

  task automatic wait_b(int n, output bit ok);
    ena_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (got_b_q.size() >= n) break;
      @(posedge clk); #1;
    end
    ok = (got_b_q.size() >= n);
  endtask

  task automatic clear_a();
    got_a_q.delete(); got_a_cyc.delete(); exp_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  logic [0:7] dir_st [4] = '{8'b10101010, 8'b10101110, 8'b11100010, 8'b10101011};
  logic [3:0] dir_d  [4] = '{4'b1011, 4'b1011, 4'b1001, 4'b1011};
  logic       dir_c  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       dir_e  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] dir_s  [4] = '{3'd0, 3'd6, 3'd7, 3'd0};
  logic [W-1:0] clean_res = {7'b0, 4'b1011, 1'b0, 1'b0, 4'd0};

  // ---------------- tests ----------------
  task automatic test_reset();
    ena_a = 0; sync_a = 0; bit_a = 0; ena_b = 0; sync_b = 0; bit_b = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid_a, data_a, corr_a, derr_a, syn_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h expected 0", {valid_a, data_a, corr_a, derr_a, syn_a});
    end
    checks++;
    if ({valid_b, data_b, corr_b, derr_b, syn_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h expected 0", {valid_b, data_b, corr_b, derr_b, syn_b});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int f, l;
    bit ok;
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      clear_a();
      send_a(st_to_fr(dir_st[i]), dir_st[i][7], 1'b0, 0, 0, 1'b0, f, l);
      wait_a(1, ok);
      e = {7'b0, dir_d[i], dir_c[i], dir_e[i], 1'b0, dir_s[i]};
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL directed[%0d] pulse: got none expected one", i);
      end else begin
        if (got_a_q[0] !== e) begin
          errors++;
          $display("FAIL directed[%0d] result: got %h expected %h", i, got_a_q[0], e);
        end
        checks++;
        if (got_a_cyc[0] !== l + 1) begin
          errors++;
          $display("FAIL directed[%0d] latency: got cycle %0d expected %0d", i, got_a_cyc[0], l + 1);
        end
      end
      idle_a(4);
      checks++;
      if ({data_a, corr_a, derr_a, syn_a} !== {dir_d[i], dir_c[i], dir_e[i], dir_s[i]}) begin
        errors++;
        $display("FAIL directed[%0d] hold: got %h expected %h", i,
                 {data_a, corr_a, derr_a, syn_a}, {dir_d[i], dir_c[i], dir_e[i], dir_s[i]});
      end
    end
  endtask

  task automatic test_sync();
    int f, l;
    bit ok;
    logic [15:0] cfr;
    cfr = st_to_fr(dir_st[0]);
    for (int k = 0; k < 4; k++) begin
      clear_a();
      if (k < 3) begin
        step_a(1'b1, 1'b0); step_a(1'b1, 1'b0); step_a(1'b0, 1'b0);
      end
      if (k == 2) begin
        ena_a = 1'b0; sync_a = 1'b1; bit_a = 1'b1;
        @(posedge clk); #1;
        sync_a = 1'b0;
      end
      // k=0: sync on first bit; k=1: same plus 2-cycle gap; k=2: sync with
      // ena low; k=3: sync right after the handoff of a complete frame.
      send_a(cfr, 1'b0, (k < 2), (k == 1) ? 4 : 0, 2, 1'b0, f, l);
      if (k == 3) begin
        sync_a = 1'b1; ena_a = 1'b0;
        @(posedge clk); #1;
        sync_a = 1'b0;
      end
      wait_a(1, ok);
      idle_a(12);
      checks++;
      if (got_a_q.size() !== 1) begin
        errors++;
        $display("FAIL sync[%0d] count: got %0d expected 1", k, got_a_q.size());
      end else begin
        checks++;
        if (got_a_q[0] !== clean_res) begin
          errors++;
          $display("FAIL sync[%0d] result: got %h expected %h", k, got_a_q[0], clean_res);
        end
        checks++;
        if (got_a_cyc[0] - f !== ((k == 1) ? 10 : 8)) begin
          errors++;
          $display("FAIL sync[%0d] timing: got %0d expected %0d", k, got_a_cyc[0] - f,
                   (k == 1) ? 10 : 8);
        end
      end
    end
  endtask

  task automatic test_random();
    int f, l, nerr, p1, p2;
    bit ok;
    logic [15:0] fr;
    logic xb;
    logic [3:0] d;
    clear_a();
    for (int i = 0; i < 40; i++) begin
      d = 4'($urandom_range(0, 15));
      fr = encode(3, {7'b0, d});
      xb = ^fr;
      nerr = $urandom_range(0, 2);
      p1 = $urandom_range(1, 8);
      p2 = (p1 % 8) + $urandom_range(1, 7);
      if (p2 > 8) p2 -= 8;
      if (nerr >= 1) begin if (p1 == 8) xb = ~xb; else fr[p1] = ~fr[p1]; end
      if (nerr == 2) begin if (p2 == 8) xb = ~xb; else fr[p2] = ~fr[p2]; end
      exp_q.push_back(model(3, 1'b1, fr, xb));
      send_a(fr, xb, 1'b0, $urandom_range(0, 8), $urandom_range(1, 3),
             (i != 39) && ($urandom_range(0, 1) == 1), f, l);
    end
    wait_a(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL random count: got %0d expected 40", got_a_q.size());
    end
    while (got_a_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, e;
      g = got_a_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL random result: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f, l;
    bit ok;
    clear_a();
    for (int i = 0; i < 6; i++)
      send_a(st_to_fr(dir_st[0]), 1'b0, 1'b0, 0, 0, (i != 5), f, l);
    wait_a(6, ok);
    idle_a(4);
    checks++;
    if (got_a_q.size() !== 6) begin
      errors++;
      $display("FAIL b2b count: got %0d expected 6", got_a_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (got_a_cyc[i] - got_a_cyc[i-1] !== 8) begin
          errors++;
          $display("FAIL b2b spacing[%0d]: got %0d expected 8", i, got_a_cyc[i] - got_a_cyc[i-1]);
        end
        checks++;
        if (got_a_q[i] !== clean_res) begin
          errors++;
          $display("FAIL b2b result[%0d]: got %h expected %h", i, got_a_q[i], clean_res);
        end
      end
    end
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", wide_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int f, l;
    bit ok;
    logic [15:0] cfr;
    cfr = st_to_fr(dir_st[0]);
    clear_a();
    send_a(cfr, 1'b0, 1'b0, 0, 0, 1'b1, f, l);
    send_a(cfr, 1'b0, 1'b0, 0, 0, 1'b1, f, l);
    for (int p = 1; p <= 4; p++) step_a(cfr[p], 1'b0);
    checks++;
    if (got_a_q.size() !== 2) begin
      errors++;
      $display("FAIL rst_mid pre count: got %0d expected 2", got_a_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, data_a, corr_a, derr_a, syn_a} !== '0) begin
      errors++;
      $display("FAIL rst_mid async clear: got %h expected 0", {valid_a, data_a, corr_a, derr_a, syn_a});
    end
    ena_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_a(20);
    checks++;
    if (got_a_q.size() !== 2) begin
      errors++;
      $display("FAIL rst_mid frame3 pulse: got %0d pulses expected 2", got_a_q.size());
    end
    // Reset between the last-bit edge and the output edge.
    send_a(cfr, 1'b0, 1'b0, 0, 0, 1'b0, f, l);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_a(10);
    checks++;
    if (got_a_q.size() !== 2) begin
      errors++;
      $display("FAIL rst_decode pulse: got %0d pulses expected 2", got_a_q.size());
    end
    send_a(cfr, 1'b0, 1'b0, 0, 0, 1'b0, f, l);
    wait_a(3, ok);
    checks++;
    if (!ok || got_a_q[2] !== clean_res) begin
      errors++;
      $display("FAIL rst_recover: got %0d pulses last %h expected %h", got_a_q.size(),
               got_a_q.size() > 2 ? got_a_q[2] : '0, clean_res);
    end
  endtask

  task automatic test_m4();
    logic [10:0] d;
    logic [15:0] fr;
    logic [W-1:0] e;
    bit ok;
    int nerr;
    got_b_q.delete();
    d = 11'($urandom_range(0, 2047));
    fr = encode(4, d);
    fr[11] = ~fr[11];
    send_b(fr);
    wait_b(1, ok);
    e = {d, 1'b1, 1'b0, 4'd11};
    checks++;
    if (!ok || got_b_q[0] !== e) begin
      errors++;
      $display("FAIL m4 pos11: got %h expected %h", ok ? got_b_q[0] : '0, e);
    end
    got_b_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      d = 11'($urandom_range(0, 2047));
      fr = encode(4, d);
      nerr = $urandom_range(0, 1);
      if (nerr == 1) begin
        int p;
        p = $urandom_range(1, 15);
        fr[p] = ~fr[p];
      end
      exp_q.push_back(model(4, 1'b0, fr, 1'b0));
      send_b(fr);
    end
    wait_b(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL m4 random count: got %0d expected 10", got_b_q.size());
    end
    while (got_b_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] g, x;
      g = got_b_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (g !== x) begin
        errors++;
        $display("FAIL m4 random result: got %h expected %h", g, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sync();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_m4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
